// File: rtl/sccb_slave.sv
// SCCB target: oversamples the 2-wire bus on clk, decodes ID / sub-address / data,
// acknowledges its own ID and exposes write strobes and read fetches to a register file.
module sccb_slave #(
    parameter logic [6:0] DEV_ID = 7'h3C
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sccb_clk,
    input  logic       sccb_data_in,
    output logic       sccb_data_out,
    output logic       sccb_data_en,
    output logic [7:0] RegAddr,
    output logic [7:0] RegWData,
    output logic       RegWr,
    input  logic [7:0] RegRData,
    output logic       Busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ID, ST_SUB, ST_WDATA, ST_RDATA, ST_IGNORE, ST_WAITSTOP
    } state_t;

    logic c_meta_r, c_sync_r, c_prev_r;
    logic d_meta_r, d_sync_r, d_prev_r;
    logic rise_s, fall_s, start_s, stop_s;
    logic [7:0] byte_s;

    state_t     state_r, state_s;
    logic [3:0] bit_cnt_r, bit_cnt_s;
    logic [7:0] shift_r, shift_s;
    logic       rw_r, rw_s;
    logic       slot_r, slot_s;
    logic       en_r, en_s;
    logic       out_r, out_s;
    logic [7:0] addr_r, addr_s;
    logic [7:0] wdata_r, wdata_s;
    logic       wr_r, wr_s;
    logic       busy_r, busy_s;

    // Two-flop synchronizers plus one history stage; idle bus level is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_meta_r <= 1'b1; c_sync_r <= 1'b1; c_prev_r <= 1'b1;
            d_meta_r <= 1'b1; d_sync_r <= 1'b1; d_prev_r <= 1'b1;
        end else begin
            c_meta_r <= sccb_clk;     c_sync_r <= c_meta_r; c_prev_r <= c_sync_r;
            d_meta_r <= sccb_data_in; d_sync_r <= d_meta_r; d_prev_r <= d_sync_r;
        end
    end

    assign rise_s  = !c_prev_r &  c_sync_r;
    assign fall_s  =  c_prev_r & !c_sync_r;
    assign start_s =  c_prev_r &  c_sync_r &  d_prev_r & !d_sync_r;
    assign stop_s  =  c_prev_r &  c_sync_r & !d_prev_r &  d_sync_r;
    assign byte_s  = {shift_r[6:0], d_sync_r};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE; bit_cnt_r <= 4'd0; shift_r <= 8'h00; rw_r <= 1'b0;
            slot_r <= 1'b0; en_r <= 1'b0; out_r <= 1'b1; addr_r <= 8'h00;
            wdata_r <= 8'h00; wr_r <= 1'b0; busy_r <= 1'b0;
        end else begin
            state_r <= state_s; bit_cnt_r <= bit_cnt_s; shift_r <= shift_s; rw_r <= rw_s;
            slot_r <= slot_s; en_r <= en_s; out_r <= out_s; addr_r <= addr_s;
            wdata_r <= wdata_s; wr_r <= wr_s; busy_r <= busy_s;
        end
    end

    // Next-state logic; slot_r marks the ack (or read reload) slot that ends on the next fall.
    always_comb begin
        state_s = state_r; bit_cnt_s = bit_cnt_r; shift_s = shift_r; rw_s = rw_r;
        slot_s = slot_r; en_s = en_r; out_s = out_r; addr_s = addr_r;
        wdata_s = wdata_r; wr_s = 1'b0; busy_s = busy_r;
        if (stop_s) begin
            state_s = ST_IDLE; busy_s = 1'b0; en_s = 1'b0; out_s = 1'b1;
            slot_s = 1'b0; bit_cnt_s = 4'd0;
        end else if (start_s) begin
            state_s = ST_ID; busy_s = 1'b1; en_s = 1'b0; out_s = 1'b1;
            slot_s = 1'b0; bit_cnt_s = 4'd0;
        end else begin
            case (state_r)
                ST_ID, ST_SUB, ST_WDATA: begin
                    if (rise_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            bit_cnt_s = 4'd0;
                        end else begin
                            shift_s   = byte_s;
                            bit_cnt_s = bit_cnt_r + 4'd1;
                            if (bit_cnt_r == 4'd7) begin
                                case (state_r)
                                    ST_ID: begin
                                        if (byte_s[7:1] == DEV_ID) rw_s = byte_s[0];
                                        else                       state_s = ST_IGNORE;
                                    end
                                    ST_SUB:   addr_s = byte_s;
                                    ST_WDATA: begin wdata_s = byte_s; wr_s = 1'b1; end
                                    default:  wr_s = 1'b0;
                                endcase
                            end else begin
                                wr_s = 1'b0;
                            end
                        end
                    end else if (fall_s) begin
                        if (slot_r) begin
                            slot_s = 1'b0; en_s = 1'b0; out_s = 1'b1;
                            case (state_r)
                                ST_ID: begin
                                    if (rw_r) begin
                                        state_s = ST_RDATA; shift_s = RegRData;
                                        en_s = 1'b1; out_s = RegRData[7];
                                    end else begin
                                        state_s = ST_SUB;
                                    end
                                end
                                ST_SUB:   state_s = ST_WDATA;
                                ST_WDATA: addr_s = addr_r + 8'd1;
                                default:  state_s = state_r;
                            endcase
                        end else if (bit_cnt_r == 4'd8) begin
                            slot_s = 1'b1; en_s = 1'b1; out_s = 1'b0;
                        end else begin
                            slot_s = 1'b0;
                        end
                    end else begin
                        wr_s = 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (rise_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            if (d_sync_r) begin
                                state_s = ST_WAITSTOP;
                            end else begin
                                bit_cnt_s = 4'd0; addr_s = addr_r + 8'd1; slot_s = 1'b1;
                            end
                        end else begin
                            bit_cnt_s = bit_cnt_r + 4'd1;
                        end
                    end else if (fall_s) begin
                        if (slot_r) begin
                            slot_s = 1'b0; shift_s = RegRData; en_s = 1'b1; out_s = RegRData[7];
                        end else if (bit_cnt_r == 4'd8) begin
                            en_s = 1'b0; out_s = 1'b1;
                        end else if (bit_cnt_r != 4'd0) begin
                            shift_s = {shift_r[6:0], 1'b1}; out_s = shift_r[6];
                        end else begin
                            out_s = out_r;
                        end
                    end else begin
                        wr_s = 1'b0;
                    end
                end
                default: begin
                    en_s = 1'b0; out_s = 1'b1;
                end
            endcase
        end
    end

    assign sccb_data_out = out_r;
    assign sccb_data_en  = en_r;
    assign RegAddr       = addr_r;
    assign RegWData      = wdata_r;
    assign RegWr         = wr_r;
    assign Busy          = busy_r;

endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: bus-level initiator model, register-file model and
// pointer/data reference model checked with immediate assertions.
module tb_sccb_slave;
    localparam logic [6:0] DEV = 7'h3C;
    localparam int Q = 4;

    logic clk = 1'b0;
    logic rstn, scl, sda_m;
    logic sda;
    logic out, en, reg_wr, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    logic [7:0] rf [256];
    logic [7:0] ref_mem [256];
    logic [7:0] model_ptr;
    logic [15:0] wr_q [$];
    logic [15:0] exp_q [$];
    int total = 0, bad = 0;
    int run_cnt = 0, last_run = 0, en_total = 0;

    always #5 clk = ~clk;

    assign sda = sda_m & (en ? out : 1'b1);
    assign reg_rdata = rf[reg_addr];

    sccb_slave #(.DEV_ID(DEV)) dut (
        .clk(clk), .rstn(rstn), .sccb_clk(scl), .sccb_data_in(sda),
        .sccb_data_out(out), .sccb_data_en(en), .RegAddr(reg_addr),
        .RegWData(reg_wdata), .RegWr(reg_wr), .RegRData(reg_rdata), .Busy(busy)
    );

    // Capture write strobes and measure drive-enable run lengths.
    always @(negedge clk) begin
        if (reg_wr) wr_q.push_back({reg_addr, reg_wdata});
        if (en) begin
            run_cnt  <= run_cnt + 1;
            en_total <= en_total + 1;
        end else if (run_cnt != 0) begin
            last_run <= run_cnt;
            run_cnt  <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wclk(Q); scl = 1'b1; wclk(Q);
        sda_m = 1'b0; wclk(Q); scl = 1'b0; wclk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wclk(Q); scl = 1'b1; wclk(Q); sda_m = 1'b1; wclk(Q);
    endtask

    task automatic wbit(input logic b);
        sda_m = b; wclk(Q); scl = 1'b1; wclk(2*Q); scl = 1'b0; wclk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input bit exp_ack, input bit chk_run, input string tag);
        logic ackv;
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        sda_m = 1'b1; wclk(Q); scl = 1'b1; wclk(Q); ackv = sda; wclk(Q); scl = 1'b0; wclk(Q);
        check({tag, " ack"}, {31'd0, ackv}, exp_ack ? 32'd0 : 32'd1);
        if (chk_run) begin
            check({tag, " ack width"}, last_run, 32'd16);
            check({tag, " ack release"}, {31'd0, en}, 32'd0);
        end
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic na, input string tag);
        logic a, b, e1, e2;
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wclk(Q); scl = 1'b1; wclk(1);
            a = sda; e1 = en; wclk(2*Q-2); b = sda; e2 = en; wclk(1);
            scl = 1'b0; wclk(Q);
            check($sformatf("%s bit%0d", tag, i), {28'd0, e1, a, e2, b},
                  {28'd0, 1'b1, exp[i], 1'b1, exp[i]});
        end
        sda_m = na; wclk(Q); scl = 1'b1; wclk(Q); e1 = en; wclk(Q); scl = 1'b0; wclk(Q);
        check({tag, " na slot en"}, {31'd0, e1}, 32'd0);
    endtask

    // Compare captured strobes with the model and commit them to the register file.
    task automatic check_writes(input string tag);
        check({tag, " wr count"}, wr_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < wr_q.size()) check($sformatf("%s wr%0d", tag, k), {16'd0, wr_q[k]}, {16'd0, exp_q[k]});
        end
        foreach (wr_q[k]) rf[wr_q[k][15:8]] = wr_q[k][7:0];
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic wr_txn(input logic [7:0] idb, input logic [7:0] sub, input int n,
                          input logic [23:0] d, input string tag);
        bit match;
        int en0;
        logic [7:0] db;
        match = (idb[7:1] == DEV) && !idb[0];
        en0 = en_total;
        bus_start();
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        write_byte(idb, match, match, {tag, " id"});
        write_byte(sub, match, match, {tag, " sub"});
        if (match) model_ptr = sub;
        for (int k = 0; k < n; k++) begin
            db = d[23-8*k -: 8];
            write_byte(db, match, match, $sformatf("%s d%0d", tag, k));
            if (match) begin
                exp_q.push_back({model_ptr, db});
                ref_mem[model_ptr] = db;
                model_ptr = model_ptr + 8'd1;
            end
        end
        check({tag, " busy before stop"}, {31'd0, busy}, 32'd1);
        bus_stop();
        wclk(Q);
        check({tag, " busy after stop"}, {31'd0, busy}, 32'd0);
        if (!match) check({tag, " en never driven"}, en_total - en0, 32'd0);
        check_writes(tag);
        check({tag, " addr"}, {24'd0, reg_addr}, {24'd0, model_ptr});
    endtask

    task automatic rd_txn(input int n, input string tag);
        bus_start();
        write_byte({DEV, 1'b1}, 1'b1, 1'b0, {tag, " id"});
        for (int k = 0; k < n; k++) begin
            read_byte(ref_mem[model_ptr], (k == n-1), $sformatf("%s r%0d", tag, k));
            if (k != n-1) model_ptr = model_ptr + 8'd1;
        end
        bus_stop();
        wclk(Q);
        check({tag, " busy after stop"}, {31'd0, busy}, 32'd0);
        check_writes(tag);
        check({tag, " addr"}, {24'd0, reg_addr}, {24'd0, model_ptr});
    endtask

    initial begin
        logic [7:0] sub;
        int n;
        for (int i = 0; i < 256; i++) begin
            rf[i] = 8'($urandom);
            ref_mem[i] = rf[i];
        end
        rf[8'h34] = 8'hC3; ref_mem[8'h34] = 8'hC3;
        model_ptr = 8'h00;
        rstn = 1'b0; scl = 1'b1; sda_m = 1'b1;
        wclk(3);
        check("reset outputs", {20'd0, en, out, reg_wr, busy, reg_addr},
              {20'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        check("reset wdata", {24'd0, reg_wdata}, 32'd0);
        rstn = 1'b1;
        wclk(4);

        wr_txn(8'h78, 8'h12, 1, {8'hA5, 16'h0}, "write");
        wr_txn(8'h78, 8'h34, 0, 24'h0, "setptr");
        rd_txn(1, "read");
        wr_txn(8'h42, 8'h10, 1, {8'h55, 16'h0}, "foreign");
        wr_txn(8'h78, 8'hFF, 2, {8'h11, 8'h22, 8'h0}, "burst");

        // Stop after sub-address, then a repeated start in the middle of a data byte.
        wr_txn(8'h78, 8'h5A, 0, 24'h0, "subonly");
        bus_start();
        write_byte(8'h78, 1'b1, 1'b1, "rs id");
        write_byte(8'h21, 1'b1, 1'b1, "rs sub");
        model_ptr = 8'h21;
        for (int i = 0; i < 4; i++) wbit(1'($urandom));
        bus_start();
        check("rs busy", {31'd0, busy}, 32'd1);
        write_byte({DEV, 1'b1}, 1'b1, 1'b0, "rs rid");
        read_byte(ref_mem[model_ptr], 1'b1, "rs r0");
        bus_stop();
        wclk(Q);
        check_writes("rs");
        check("rs addr", {24'd0, reg_addr}, {24'd0, model_ptr});

        // Asynchronous reset while the target is driving read bit 3.
        bus_start();
        write_byte({DEV, 1'b1}, 1'b1, 1'b0, "rst id");
        for (int i = 0; i < 4; i++) wbit(1'b1);
        sda_m = 1'b1; wclk(Q); scl = 1'b1; wclk(2);
        #2 rstn = 1'b0;
        #1 check("async reset", {21'd0, en, out, busy, reg_addr}, {21'd0, 1'b0, 1'b1, 1'b0, 8'h00});
        model_ptr = 8'h00;
        wclk(2);
        rstn = 1'b1;
        wclk(2);
        scl = 1'b0; wclk(Q);
        bus_stop();
        wclk(Q);
        check_writes("rst");
        wr_txn(8'h78, 8'h80, 2, {8'h9C, 8'h3E, 8'h0}, "post reset");

        // Randomized write bursts followed by read-back.
        for (int r = 0; r < 3; r++) begin
            sub = 8'($urandom);
            n = $urandom_range(1, 3);
            wr_txn(8'h78, sub, n, 24'($urandom), $sformatf("rnd%0d w", r));
            wr_txn(8'h78, sub, 0, 24'h0, $sformatf("rnd%0d p", r));
            rd_txn(n, $sformatf("rnd%0d r", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
